// File: rtl/event_sequencer_if.sv
// rtl/event_sequencer_if.sv - event/strobe bundle between event lines, sequencer and counter
// Purpose: groups the event inputs, the downstream stall and the sequencer outputs.
// Ports (signals):
//   EvA, EvB  event lines (level, rising edge = one event)
//   Hold      downstream stall, no pop while 1
//   En, Slt   one-cycle strobe and channel tag toward the dual event counter
//   Count     FIFO occupancy, $clog2(DEPTH)+1 bits
//   Overflow  sticky drop flag
//   Drops     saturating dropped-event count
// Modports: master drives events/Hold, slave is the sequencer side.
interface event_sequencer_if #(
  parameter int DEPTH = 8
);
  logic                   EvA;
  logic                   EvB;
  logic                   Hold;
  logic                   En;
  logic                   Slt;
  logic [$clog2(DEPTH):0] Count;
  logic                   Overflow;
  logic [7:0]             Drops;

  modport master (
    output EvA, EvB, Hold,
    input  En, Slt, Count, Overflow, Drops
  );

  modport slave (
    input  EvA, EvB, Hold,
    output En, Slt, Count, Overflow, Drops
  );
endinterface

// File: rtl/event_sequencer.sv
// rtl/event_sequencer.sv - edge-detecting event FIFO that serializes two event lines into En/Slt
// Purpose: detects rising edges on EvA/EvB, buffers them (A before B when simultaneous)
//          in a DEPTH-entry circular buffer of 1-bit tags, and replays one per cycle.
// Ports:
//   Clk    system clock, all state on posedge
//   Reset  synchronous, active-high; empties the FIFO and clears all outputs
//   bus    event_sequencer_if.slave: EvA, EvB, Hold in; En, Slt, Count, Overflow, Drops out
module event_sequencer #(
  parameter int DEPTH = 8
) (
  input logic              Clk,
  input logic              Reset,
  event_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Only the channel tag needs storing: 0 = A, 1 = B.
  logic [DEPTH-1:0] tags;
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             pa;
  logic             pb;
  logic             en_q;
  logic             slt_q;
  logic             overflow_q;
  logic [7:0]       drops;

  logic             edge_a;
  logic             edge_b;
  logic             acc_a;
  logic             acc_b;
  logic             pop;
  logic [CW-1:0]    free;
  logic [AW-1:0]    wptr_b;
  logic [1:0]       ndrop;
  logic [8:0]       drops_sum;

  always_comb begin
    edge_a    = bus.EvA & ~pa;
    edge_b    = bus.EvB & ~pb;
    // Free space uses occupancy before this cycle's pop, so a full FIFO
    // drops incoming edges even while it is draining.
    free      = CW'(DEPTH) - count;
    acc_a     = edge_a & (free != '0);
    acc_b     = edge_b & (free > CW'(acc_a));
    ndrop     = {1'b0, edge_a & ~acc_a} + {1'b0, edge_b & ~acc_b};
    drops_sum = {1'b0, drops} + {7'd0, ndrop};
    pop       = (count != '0) & ~bus.Hold;
    // B lands in the slot after A's when both are accepted together.
    wptr_b    = wptr + AW'(acc_a);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      // A line already high through reset must not look like a fresh edge.
      pa         <= bus.EvA;
      pb         <= bus.EvB;
      en_q       <= 1'b0;
      slt_q      <= 1'b0;
      overflow_q <= 1'b0;
      drops      <= '0;
    end else begin
      pa <= bus.EvA;
      pb <= bus.EvB;
      if (acc_a) tags[wptr]   <= 1'b0;
      if (acc_b) tags[wptr_b] <= 1'b1;
      wptr  <= wptr + AW'(acc_a) + AW'(acc_b);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(acc_a) + CW'(acc_b) - CW'(pop);
      en_q  <= pop;
      slt_q <= pop & tags[rptr];
      if (ndrop != 2'd0) overflow_q <= 1'b1;
      drops <= (drops_sum > 9'd255) ? 8'd255 : drops_sum[7:0];
    end
  end

  assign bus.En       = en_q;
  assign bus.Slt      = slt_q;
  assign bus.Count    = count;
  assign bus.Overflow = overflow_q;
  assign bus.Drops    = drops;
endmodule

// File: tb/tb_event_sequencer.sv
// tb/tb_event_sequencer.sv - self-checking bench for event_sequencer against a queue model
module tb_event_sequencer;
  localparam int DEPTH = 8;

  logic Clk = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  event_sequencer_if #(.DEPTH(DEPTH)) bus ();

  event_sequencer #(.DEPTH(DEPTH)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Reference model: a queue of tags plus the observable registers.
  bit q[$];
  bit m_pa, m_pb, m_en, m_slt, m_ovf;
  int m_drops;

  function automatic logic [14:0] obs_vec();
    return {bus.En, bus.Slt, bus.Count, bus.Overflow, bus.Drops};
  endfunction

  function automatic logic [14:0] exp_vec();
    logic [3:0] c;
    logic [7:0] d;
    c = 4'(q.size());
    d = 8'(m_drops);
    return {m_en, m_slt, c, m_ovf, d};
  endfunction

  // Drive one cycle, advance the model at the edge, return #1 after it.
  task automatic tick(input bit a, input bit b, input bit h, input bit r);
    bit ea, eb, pop, head;
    int free, acc, nd;
    bus.EvA  = a;
    bus.EvB  = b;
    bus.Hold = h;
    Reset    = r;
    @(posedge Clk);
    if (r) begin
      q.delete();
      m_pa = a; m_pb = b;
      m_en = 0; m_slt = 0; m_ovf = 0; m_drops = 0;
    end else begin
      ea = a && !m_pa;
      eb = b && !m_pb;
      m_pa = a; m_pb = b;
      free = DEPTH - q.size();
      pop  = (q.size() > 0) && !h;
      head = pop ? q[0] : 1'b0;
      if (pop) void'(q.pop_front());
      acc = 0; nd = 0;
      if (ea) begin
        if (free >= 1) begin q.push_back(1'b0); acc = 1; end
        else nd++;
      end
      if (eb) begin
        if (free >= 1 + acc) q.push_back(1'b1);
        else nd++;
      end
      m_drops = (m_drops + nd > 255) ? 255 : m_drops + nd;
      if (nd > 0) m_ovf = 1;
      m_en  = pop;
      m_slt = head;
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 1);
    tick(1, 0, 0, 1);
    n_checks++;
    if (obs_vec() !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", obs_vec(), 15'd0);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 0, 0);
      n_checks++;
      if (bus.En !== 1'b0 || bus.Count !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_level_suppress: En=%b Count=%0d expected En=0 Count=0", bus.En, bus.Count);
      end
    end
  endtask

  task automatic test_single();
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    n_checks++;
    if (bus.Count !== 4'd1 || bus.En !== 1'b0) begin
      n_fail++;
      $display("FAIL single_capture: Count=%0d En=%b expected 1/0", bus.Count, bus.En);
    end
    tick(0, 0, 0, 0);
    n_checks++;
    if (bus.En !== 1'b1 || bus.Slt !== 1'b0 || bus.Count !== 4'd0) begin
      n_fail++;
      $display("FAIL single_strobe: En=%b Slt=%b Count=%0d expected 1/0/0", bus.En, bus.Slt, bus.Count);
    end
    tick(0, 0, 0, 0);
    n_checks++;
    if (bus.En !== 1'b0) begin
      n_fail++;
      $display("FAIL single_one_cycle: En=%b expected 0", bus.En);
    end
  endtask

  task automatic test_simultaneous();
    logic [5:0] got;
    tick(0, 0, 0, 0);
    tick(1, 1, 0, 0);
    n_checks++;
    if (bus.Count !== 4'd2) begin
      n_fail++;
      $display("FAIL simul_capture: Count=%0d expected 2", bus.Count);
    end
    tick(0, 0, 0, 0); got[5:4] = {bus.En, bus.Slt};
    tick(0, 0, 0, 0); got[3:2] = {bus.En, bus.Slt};
    tick(0, 0, 0, 0); got[1:0] = {bus.En, bus.Slt};
    n_checks++;
    if (got !== 6'b10_11_00) begin
      n_fail++;
      $display("FAIL simul_order: En/Slt seq=%b expected %b", got, 6'b101100);
    end
  endtask

  task automatic test_overflow();
    tick(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      tick(1, 1, 1, 0);
      tick(0, 0, 1, 0);
    end
    n_checks++;
    if (bus.Count !== 4'd8 || bus.Drops !== 8'd2 || bus.Overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_state: Count=%0d Drops=%0d Ovf=%b expected 8/2/1",
               bus.Count, bus.Drops, bus.Overflow);
    end
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0, 0);
      n_checks++;
      if (bus.En !== 1'b1 || bus.Slt !== 1'(i % 2)) begin
        n_fail++;
        $display("FAIL overflow_drain[%0d]: En=%b Slt=%b expected 1/%0d", i, bus.En, bus.Slt, i % 2);
      end
    end
    tick(0, 0, 0, 0);
    n_checks++;
    if (bus.En !== 1'b0 || bus.Overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_end: En=%b Ovf=%b expected 0/1", bus.En, bus.Overflow);
    end
  endtask

  task automatic test_hold_saturation();
    logic [9:0] en_seq;
    logic [5:0] slt_seq;
    bit hseq[10] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
    tick(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 1, 0);
      tick(0, 0, 1, 0);
    end
    en_seq = '0;
    slt_seq = '0;
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, hseq[i], 0);
      en_seq = {en_seq[8:0], bus.En};
      if (bus.En) slt_seq = {slt_seq[4:0], bus.Slt};
    end
    n_checks++;
    if (en_seq !== 10'b1100011110 || slt_seq !== 6'b010101) begin
      n_fail++;
      $display("FAIL hold_gap: En seq=%b Slt seq=%b expected %b %b",
               en_seq, slt_seq, 10'b1100011110, 6'b010101);
    end
    for (int i = 0; i < 154; i++) begin
      tick(1, 1, 1, 0);
      tick(0, 0, 1, 0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL sat_model[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (bus.Drops !== 8'd255 || bus.Count !== 4'd8 || bus.Overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_saturate: Drops=%0d Count=%0d Ovf=%b expected 255/8/1",
               bus.Drops, bus.Count, bus.Overflow);
    end
  endtask

  task automatic test_reset_midburst();
    tick(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 1, 0);
      tick(0, 0, 1, 0);
    end
    tick(0, 0, 0, 0);
    n_checks++;
    if (bus.Count !== 4'd5 || bus.En !== 1'b1) begin
      n_fail++;
      $display("FAIL midburst_setup: Count=%0d En=%b expected 5/1", bus.Count, bus.En);
    end
    tick(0, 0, 0, 1);
    n_checks++;
    if (obs_vec() !== 15'd0) begin
      n_fail++;
      $display("FAIL midburst_reset: got %h expected %h", obs_vec(), 15'd0);
    end
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 0);
      n_checks++;
      if (bus.En !== 1'b0 || bus.Count !== 4'd0) begin
        n_fail++;
        $display("FAIL midburst_stale[%0d]: En=%b Count=%0d expected 0/0", i, bus.En, bus.Count);
      end
    end
  endtask

  task automatic test_random();
    bit a, b, h, r;
    for (int i = 0; i < 3000; i++) begin
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      h = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 299) == 0);
      tick(a, b, h, r);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.EvA  = 1'b0;
    bus.EvB  = 1'b0;
    bus.Hold = 1'b0;
    Reset    = 1'b1;
    test_reset();
    test_single();
    test_simultaneous();
    test_overflow();
    test_hold_saturation();
    test_reset_midburst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
